rs232_rx_fsm: RTL

- Control and datapath stage of the RS232 receiver. It consumes the baud-tick `flag` of the `counter_rx` bit-timing counter and drives that counter's enable and terminal-count inputs.
- It synchronises the serial line, detects and validates the start bit, and samples 8 data bits LSB-first at mid-bit.
- It checks the stop bit and presents the received byte with a one-cycle valid strobe and a frame-error flag.

---
 rtl/rs232_rx_fsm.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/rs232_rx_fsm.sv
// -----------------------------------------------------------------------------
// rs232_rx_fsm
//
// Control and datapath stage of an RS232 receiver. Works together with an
// external bit-timing counter (counter_rx): this block enables that counter and
// programs its terminal count. It consumes the counter's one-cycle tick to
// sample the serial line at the middle of every bit.
//
// Frame format: one start bit (0), 8 data bits LSB first, one stop bit (1).
//
// Ports
//   clk_i    in   1      system clock
//   rst_i    in   1      synchronous, active-high reset
//   rx_i     in   1      asynchronous serial line, idle high
//   flag_i   in   1      one-cycle tick from counter_rx (flag_o)
//   en_o     out  1      counter enable (to counter_rx en_i)
//   vmax_o   out  Width  counter terminal count (to counter_rx vmax_i)
//   data_o   out  8      last received byte
//   valid_o  out  1      one-cycle strobe, data_o was just updated
//   ferr_o   out  1      stop bit of the last frame was sampled low
//   busy_o   out  1      frame reception in progress
//
// Parameters
//   Width    width of vmax_o, must match the counter_rx instance
//   BitMax   terminal count for a full bit period (BitMax+1 clocks per bit)
//   HalfMax  terminal count for the half-bit alignment after the start edge
// -----------------------------------------------------------------------------
module rs232_rx_fsm #(
  parameter int unsigned Width   = 10,
  parameter int unsigned BitMax  = 433,
  parameter int unsigned HalfMax = 216
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             rx_i,
  input  logic             flag_i,
  output logic             en_o,
  output logic [Width-1:0] vmax_o,
  output logic [7:0]       data_o,
  output logic             valid_o,
  output logic             ferr_o,
  output logic             busy_o
);

  localparam logic [Width-1:0] VmaxHalf = Width'(HalfMax);
  localparam logic [Width-1:0] VmaxBit  = Width'(BitMax);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_t;

  // Synchroniser flops; both come out of reset high so that an idle line
  // is never mistaken for a start edge.
  logic rx_meta_q;
  logic rx_sync_q;
  logic rx_s;

  // FSM and datapath registers
  state_t             state_q,   state_d;
  logic [7:0]         shreg_q,   shreg_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         data_q,    data_d;
  logic               valid_q,   valid_d;
  logic               ferr_q,    ferr_d;

  // Moore outputs, registered from the next state so they line up with
  // state_q exactly and never glitch.
  logic               en_q,      en_d;
  logic               busy_q,    busy_d;
  logic [Width-1:0]   vmax_q,    vmax_d;

  assign rx_s = rx_sync_q;

  // Two-flop synchroniser for the asynchronous serial input.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = ferr_q;

    case (state_q)
      IDLE: begin
        // A low line starts the half-bit alignment period.
        if (!rx_s) begin
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end

      START: begin
        // Middle of the start bit: a high line means the edge was a glitch.
        if (flag_i) begin
          if (!rx_s) begin
            state_d   = DATA;
            bit_idx_d = 3'd0;
          end else begin
            state_d   = IDLE;
          end
        end else begin
          state_d = START;
        end
      end

      DATA: begin
        // LSB arrives first, so shift in from the top.
        if (flag_i) begin
          shreg_d   = {rx_s, shreg_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = DATA;
        end
      end

      STOP: begin
        // Byte is published whatever the stop bit value; ferr flags a bad one.
        if (flag_i) begin
          data_d  = shreg_q;
          valid_d = 1'b1;
          ferr_d  = ~rx_s;
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d = BRK;
          end
        end else begin
          state_d = STOP;
        end
      end

      BRK: begin
        // Line held low after a frame: wait for it to go idle before
        // accepting another start edge.
        if (rx_s) begin
          state_d = IDLE;
        end else begin
          state_d = BRK;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Moore output decode from the next state.
  always_comb begin
    en_d   = 1'b0;
    busy_d = 1'b1;
    vmax_d = VmaxBit;
    case (state_d)
      IDLE: begin
        en_d   = 1'b0;
        busy_d = 1'b0;
        vmax_d = VmaxHalf;
      end
      START: begin
        en_d   = 1'b1;
        busy_d = 1'b1;
        vmax_d = VmaxHalf;
      end
      DATA: begin
        en_d   = 1'b1;
        busy_d = 1'b1;
        vmax_d = VmaxBit;
      end
      STOP: begin
        en_d   = 1'b1;
        busy_d = 1'b1;
        vmax_d = VmaxBit;
      end
      BRK: begin
        en_d   = 1'b0;
        busy_d = 1'b1;
        vmax_d = VmaxBit;
      end
      default: begin
        en_d   = 1'b0;
        busy_d = 1'b0;
        vmax_d = VmaxHalf;
      end
    endcase
  end

  // State, datapath and registered output flops.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      shreg_q   <= 8'h00;
      bit_idx_q <= 3'd0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
      vmax_q    <= VmaxHalf;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      en_q      <= en_d;
      busy_q    <= busy_d;
      vmax_q    <= vmax_d;
    end
  end

  assign en_o    = en_q;
  assign busy_o  = busy_q;
  assign vmax_o  = vmax_q;
  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign ferr_o  = ferr_q;

endmodule
